// File: rtl/snn_pkg.sv
// Shared types and constants for the SNN layer sequencer slice.
package snn_pkg;

  localparam int SNN_DATA_W = 8;
  localparam int FANIN      = 4;
  // Tag index is sized for the largest supported layer (256 neurons).
  localparam int TAG_IDX_W  = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    OUT
  } seq_state_t;

  // Travels alongside an issued slice so the result can be steered on return.
  typedef struct packed {
    logic                 valid;
    logic [TAG_IDX_W-1:0] index;
    logic                 force_zero;
  } tag_t;

endpackage

// File: rtl/snn_result_bank.sv
// NUM_NEURONS x DATA_W result register file: one write port, clear on frame
// accept, async reset, whole bank exposed as a flat read-out vector.
module snn_result_bank
  import snn_pkg::*;
#(
  parameter int NUM_NEURONS = 8,
  parameter int DATA_W      = SNN_DATA_W
)(
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_clr,
  input  logic                          i_we,
  input  logic [TAG_IDX_W-1:0]          i_waddr,
  input  logic [DATA_W-1:0]             i_wdata,
  output logic [NUM_NEURONS*DATA_W-1:0] o_rdata
);

  for (genvar n = 0; n < NUM_NEURONS; n++) begin : g_ent
    logic [DATA_W-1:0] ent_q;

    // Entry n: clear wins over a write landing in the same cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)                                       ent_q <= '0;
      else if (i_clr)                                  ent_q <= '0;
      else if (i_we && (i_waddr == TAG_IDX_W'(n)))     ent_q <= i_wdata;
    end

    assign o_rdata[n*DATA_W +: DATA_W] = ent_q;
  end

endmodule

// File: rtl/snn_layer_sequencer.sv
// Time-multiplexes one shared 4-input neuron datapath over NUM_NEURONS
// logical neurons: capture frame, issue one slice per cycle, collect the
// 1-cycle-latency results, present the layer output over valid/ready.
// Optional build macro: SNN_SEQ_ZERO_SKIP_EN (suppress issue of all-zero
// slices and force their result to zero).
module snn_layer_sequencer
  import snn_pkg::*;
#(
  parameter int NUM_NEURONS = 8,
  parameter int DATA_W      = SNN_DATA_W,
  parameter int DP_LATENCY  = 1
)(
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic                                i_frame_valid,
  output logic                                o_frame_ready,
  input  logic [NUM_NEURONS*FANIN*DATA_W-1:0] i_frame_data,
  output logic [DATA_W-1:0]                   o_dp_data0,
  output logic [DATA_W-1:0]                   o_dp_data1,
  output logic [DATA_W-1:0]                   o_dp_data2,
  output logic [DATA_W-1:0]                   o_dp_data3,
  output logic                                o_dp_valid,
  input  logic [DATA_W-1:0]                   i_dp_result,
  output logic                                o_out_valid,
  input  logic                                i_out_ready,
  output logic [NUM_NEURONS*DATA_W-1:0]       o_out_data,
  output logic                                o_busy
);

  localparam int               IDX_W    = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

  if (DP_LATENCY != 1) begin : g_lat_chk
    $error("snn_layer_sequencer: only DP_LATENCY == 1 is supported");
  end
  if ((NUM_NEURONS < 2) || (NUM_NEURONS > (1 << TAG_IDX_W))) begin : g_n_chk
    $error("snn_layer_sequencer: NUM_NEURONS must be in 2..256");
  end

  logic [NUM_NEURONS-1:0][FANIN-1:0][DATA_W-1:0] frame_q;
  logic [FANIN-1:0][DATA_W-1:0]                  slice;
  seq_state_t                                    state_q, state_d;
  logic [IDX_W-1:0]                              idx_q;
  logic                                          rdy_q;
  logic                                          accept;
  logic                                          issue;
  logic                                          slice_zero;
  tag_t                                          tag_in;
  tag_t                                          tag_pipe [DP_LATENCY];
  tag_t                                          tag_out;
  logic [DATA_W-1:0]                             wdata;

  assign slice   = frame_q[idx_q];
  assign accept  = i_frame_valid && rdy_q;
  assign tag_out = tag_pipe[DP_LATENCY-1];
  assign wdata   = tag_out.force_zero ? '0 : i_dp_result;

  // Ready is registered so it stays low while reset is held and rises on the
  // first edge after release; elsewhere it tracks "state is IDLE".
  assign o_frame_ready = rdy_q;

`ifdef SNN_SEQ_ZERO_SKIP_EN
  assign slice_zero = (slice == '0);
`else
  assign slice_zero = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and datapath-facing outputs.
  always_comb begin
    state_d     = state_q;
    issue       = 1'b0;
    o_dp_valid  = 1'b0;
    o_dp_data0  = '0;
    o_dp_data1  = '0;
    o_dp_data2  = '0;
    o_dp_data3  = '0;
    o_out_valid = 1'b0;
    o_busy      = (state_q != IDLE);
    case (state_q)
      IDLE:  if (accept) state_d = ISSUE;
      ISSUE: begin
        issue      = 1'b1;
        o_dp_valid = !slice_zero;
        if (!slice_zero) begin
          o_dp_data0 = slice[0];
          o_dp_data1 = slice[1];
          o_dp_data2 = slice[2];
          o_dp_data3 = slice[3];
        end
        if (idx_q == LAST_IDX) state_d = DRAIN;
      end
      DRAIN: state_d = OUT;
      OUT: begin
        o_out_valid = 1'b1;
        if (i_out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered frame-ready flag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) rdy_q <= 1'b0;
    else       rdy_q <= (state_d == IDLE);
  end

  // Neuron index: restarts on accept, saturates at the last neuron.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                            idx_q <= '0;
    else if (accept)                      idx_q <= '0;
    else if (issue && idx_q != LAST_IDX)  idx_q <= idx_q + 1'b1;
  end

  // Input frame capture; the source may change freely after accept.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)       frame_q <= '0;
    else if (accept) frame_q <= i_frame_data;
  end

  // Tag for the slice going out this cycle.
  always_comb begin
    tag_in = '0;
    if (issue) begin
      tag_in.valid      = 1'b1;
      tag_in.index      = TAG_IDX_W'(idx_q);
      tag_in.force_zero = slice_zero;
    end
  end

  // Tag pipe matched to the datapath latency.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DP_LATENCY; i++) tag_pipe[i] <= '0;
    end else begin
      tag_pipe[0] <= tag_in;
      for (int i = 1; i < DP_LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  snn_result_bank #(
    .NUM_NEURONS (NUM_NEURONS),
    .DATA_W      (DATA_W)
  ) u_bank (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (accept),
    .i_we    (tag_out.valid),
    .i_waddr (tag_out.index),
    .i_wdata (wdata),
    .o_rdata (o_out_data)
  );

endmodule

// File: tb/tb_snn_layer_sequencer.sv
// Self-checking bench for snn_layer_sequencer (N=8, DATA_W=8) with a bench
// datapath computing a registered 4-byte sum, threshold 1, 0xFF when idle.
module tb_snn_layer_sequencer;

  localparam int N  = 8;
  localparam int DW = 8;
  localparam int FW = N*4*DW;
  localparam int OW = N*DW;
`ifdef SNN_SEQ_ZERO_SKIP_EN
  localparam bit ZS = 1'b1;
`else
  localparam bit ZS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          frame_valid;
  logic          frame_ready;
  logic [FW-1:0] frame_data;
  logic [DW-1:0] d0, d1, d2, d3;
  logic          dp_valid;
  logic [DW-1:0] dp_result = 8'hFF;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic          busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  snn_layer_sequencer #(.NUM_NEURONS(N), .DATA_W(DW), .DP_LATENCY(1)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_frame_valid(frame_valid), .o_frame_ready(frame_ready), .i_frame_data(frame_data),
    .o_dp_data0(d0), .o_dp_data1(d1), .o_dp_data2(d2), .o_dp_data3(d3),
    .o_dp_valid(dp_valid), .i_dp_result(dp_result),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_data(out_data),
    .o_busy(busy)
  );

  function automatic logic [7:0] dp_fn(input logic [31:0] ops);
    int s = 0;
    for (int j = 0; j < 4; j++) s += int'(ops[j*8 +: 8]);
    s = s % 256;
    return (s >= 1) ? 8'(s) : 8'h00;
  endfunction

  always @(posedge clk) dp_result <= dp_valid ? dp_fn({d3, d2, d1, d0}) : 8'hFF;

  task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: neuron n output = low byte of the sum of its four input bytes.
  function automatic logic [OW-1:0] model_out(input logic [FW-1:0] f);
    logic [OW-1:0] r = '0;
    for (int n = 0; n < N; n++) begin
      int s = 0;
      for (int j = 0; j < 4; j++) s += int'(f[(4*n+j)*8 +: 8]);
      r[n*8 +: 8] = 8'(s % 256);
    end
    return r;
  endfunction

  function automatic bit is_zero(input logic [FW-1:0] f, input int n);
    return f[n*32 +: 32] == 32'h0;
  endfunction

  function automatic logic [15:0] model_vmask(input logic [FW-1:0] f);
    logic [15:0] m = '0;
    for (int n = 0; n < N; n++) if (!(ZS && is_zero(f, n))) m[n+1] = 1'b1;
    return m;
  endfunction

  function automatic logic [FW-1:0] rand_frame(input bit allow_zero);
    logic [FW-1:0] f;
    for (int k = 0; k < FW/32; k++) f[k*32 +: 32] = $urandom;
    if (allow_zero)
      for (int n = 0; n < N; n++) if ($urandom_range(0, 3) == 0) f[n*32 +: 32] = '0;
    return f;
  endfunction

  function automatic logic [FW-1:0] set_byte(input logic [FW-1:0] f, input int n, input int j, input logic [7:0] v);
    logic [FW-1:0] r = f;
    r[(4*n+j)*8 +: 8] = v;
    return r;
  endfunction

  // Called at a negedge: offer f, wait for accept; returns at negedge of cycle 1.
  task automatic offer(input logic [FW-1:0] f);
    int w = 0;
    frame_data  = f;
    frame_valid = 1'b1;
    while (!frame_ready && w < 50) begin @(negedge clk); w++; end
    chk("accept_wait", frame_ready, 1);
    @(negedge clk);
    frame_valid = 1'b0;
    frame_data  = rand_frame(1'b0);
  endtask

  // From negedge of cycle 1: watch issues until o_out_valid, check timing.
  task automatic collect(input logic [FW-1:0] f);
    logic [15:0] vm = '0;
    int lat = -1;
    for (int c = 1; c < 40; c++) begin
      if (out_valid) begin lat = c; break; end
      if (c < 16) vm[c] = dp_valid;
      if (c <= N) chk("dp_ops", {d3, d2, d1, d0}, f[(c-1)*32 +: 32]);
      else        chk("dp_ops_drain", {dp_valid, d3, d2, d1, d0}, 0);
      chk("busy", busy, 1);
      chk("frame_ready_busy", frame_ready, 0);
      @(negedge clk);
    end
    chk("latency", lat, N + 2);
    chk("dp_valid_pattern", vm, model_vmask(f));
  endtask

  task automatic hold_out(input int cycles, input logic [OW-1:0] exp);
    for (int i = 0; i < cycles; i++) begin
      chk("out_valid_hold", out_valid, 1);
      chk("out_data_hold", out_data, exp);
      chk("frame_ready_out", frame_ready, 0);
      @(negedge clk);
    end
  endtask

  task automatic handshake(input string name, input logic [OW-1:0] exp);
    chk(name, out_data, exp);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_after_hs", out_valid, 0);
    chk("frame_ready_after_hs", frame_ready, 1);
  endtask

  typedef struct {
    logic [FW-1:0] frame;
    logic [OW-1:0] exp;
    int            hold;
  } vec_t;

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t          tbl [4];
    logic [FW-1:0] fa, fb;
    logic [FW-1:0] fr [3];
    int            acc [$];
    logic [OW-1:0] outs [$];
    int            nacc;
    bit            pend;
    bit            seen;

    // Directed table; expected bytes worked out by hand.
    for (int i = 0; i < 4; i++) begin
      tbl[i].frame = '0; tbl[i].exp = '0; tbl[i].hold = 0;
    end
    for (int n = 0; n < N; n++) begin
      tbl[0].frame = set_byte(tbl[0].frame, n, 0, 8'(n));
      tbl[0].frame = set_byte(tbl[0].frame, n, 1, 8'd1);
      tbl[0].exp[n*8 +: 8] = 8'(n + 1);
      tbl[2].frame = set_byte(tbl[2].frame, n, 0, 8'(n));
      tbl[2].frame = set_byte(tbl[2].frame, n, 1, 8'(2*n));
      tbl[2].frame = set_byte(tbl[2].frame, n, 2, 8'(3*n));
      tbl[2].frame = set_byte(tbl[2].frame, n, 3, 8'(4*n));
      tbl[2].exp[n*8 +: 8] = 8'(10*n);
      if (n != 2 && n != 5) begin
        tbl[3].frame = set_byte(tbl[3].frame, n, 0, 8'(n + 1));
        tbl[3].frame = set_byte(tbl[3].frame, n, 1, 8'h80);
        tbl[3].frame = set_byte(tbl[3].frame, n, 2, 8'h80);
        tbl[3].frame = set_byte(tbl[3].frame, n, 3, 8'd3);
        tbl[3].exp[n*8 +: 8] = 8'(n + 4);
      end
    end
    tbl[1].frame = {FW{1'b1}};
    tbl[1].exp   = {N{8'hFC}};
    tbl[1].hold  = 3;
    tbl[3].hold  = 1;

    // Reset state
    rst = 1'b1; frame_valid = 1'b0; out_ready = 1'b0; frame_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_outputs", {frame_ready, dp_valid, out_valid, busy, d0, d1, d2, d3}, 0);
    chk("rst_out_data", out_data, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", frame_ready, 1);
    chk("busy_idle", busy, 0);

    // Table vectors
    for (int i = 0; i < 4; i++) begin
      offer(tbl[i].frame);
      collect(tbl[i].frame);
      hold_out(tbl[i].hold, tbl[i].exp);
      handshake($sformatf("tbl%0d_out", i), tbl[i].exp);
    end

    // Backpressure: 20 cycles in OUT while a new frame is offered.
    fa = rand_frame(1'b1);
    fb = rand_frame(1'b1);
    offer(fa);
    collect(fa);
    frame_data = fb; frame_valid = 1'b1;
    hold_out(20, model_out(fa));
    chk("bp_out_data", out_data, model_out(fa));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_ready_after_hs", frame_ready, 1);
    @(negedge clk);
    frame_valid = 1'b0;
    frame_data  = '0;
    collect(fb);
    handshake("bp_second_frame", model_out(fb));

    // Back-to-back frames, valid and ready held high.
    for (int i = 0; i < 3; i++) fr[i] = rand_frame(1'b1);
    nacc = 0; pend = 1'b0;
    frame_data = fr[0]; frame_valid = 1'b1; out_ready = 1'b1;
    for (int cyc = 0; cyc < 80; cyc++) begin
      if (frame_valid && frame_ready) begin acc.push_back(cyc); nacc++; pend = 1'b1; end
      if (out_valid) outs.push_back(out_data);
      if (outs.size() == 3) break;
      @(negedge clk);
      if (pend) begin
        pend = 1'b0;
        if (nacc < 3) frame_data = fr[nacc];
        else          frame_valid = 1'b0;
      end
    end
    @(negedge clk);
    out_ready = 1'b0; frame_valid = 1'b0;
    chk("b2b_accepts", acc.size(), 3);
    chk("b2b_outputs", outs.size(), 3);
    if (acc.size() == 3) begin
      chk("b2b_spacing1", acc[1] - acc[0], N + 3);
      chk("b2b_spacing2", acc[2] - acc[1], N + 3);
    end
    for (int i = 0; i < outs.size() && i < 3; i++)
      chk($sformatf("b2b_out%0d", i), outs[i], model_out(fr[i]));

    // Reset during ISSUE at index 4.
    @(negedge clk);
    fa = rand_frame(1'b0);
    offer(fa);
    repeat (4) @(negedge clk);
    chk("mid_issue_ops", {d3, d2, d1, d0}, fa[4*32 +: 32]);
    rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("mid_rst_outputs", {frame_ready, dp_valid, out_valid, busy, d0, d1, d2, d3}, 0);
      chk("mid_rst_out_data", out_data, 0);
      @(negedge clk);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_mid_rst", frame_ready, 1);
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid || busy) seen = 1'b1;
      @(negedge clk);
    end
    chk("no_output_after_rst", seen, 0);

    // Randomized frames against the reference model.
    for (int i = 0; i < 12; i++) begin
      fa = rand_frame(1'b1);
      offer(fa);
      collect(fa);
      hold_out($urandom_range(0, 3), model_out(fa));
      handshake("rand_out", model_out(fa));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
